// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if
// Read-only instruction-memory bus between the fetch stage and memory.
//   imem_req    fetch stage -> memory  read request
//   imem_addr   fetch stage -> memory  word address (ADDR_W bits)
//   imem_rdata  memory -> fetch stage  read data, meaningful with imem_ack
//   imem_ack    memory -> fetch stage  completes the outstanding read
// Modports: master = fetch stage, slave = memory.
// ---------------------------------------------------------------------------
interface ifetch_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
// Instruction fetch stage for the SISC processor. Holds the program counter,
// reads instruction memory over a req/ack handshake, and latches the word
// into the instruction register feeding the sisc datapath.
//   clk, rst_f        clock, asynchronous active-high reset
//   imem              instruction-memory bus (ifetch_if.master)
//   ir_ld             controller: current instruction done, fetch next
//   br_taken, br_rel  controller: redirect PC (relative or absolute)
//   br_imm            branch immediate
//   halt              controller: stop fetching (wins over br_taken)
//   instruction       instruction register
//   ir_valid          instruction holds a fetched, unconsumed word
//   pc                address of the next word to fetch
//   fetch_err         one-cycle pulse when memory fails to ack in time
//   halted            stage has stopped; only reset leaves this
// ---------------------------------------------------------------------------
module ifetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  ifetch_if.master          imem,
  input  logic              ir_ld,
  input  logic              br_taken,
  input  logic              br_rel,
  input  logic [15:0]       br_imm,
  input  logic              halt,
  output logic [31:0]       instruction,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err,
  output logic              halted
);

  // The wait counter must be able to hold WAIT_MAX itself.
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int EXT_W = ADDR_W + 16;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_rel_tgt;
  logic [ADDR_W-1:0] br_abs_tgt;
  logic [31:0]       instruction_d;
  logic              ir_valid_d;
  logic              fetch_err_d;

  // The PC is already post-incremented when a branch is resolved in HOLD, so
  // the relative target is simply pc + sign-extended immediate, modulo 2^ADDR_W.
  assign pc_inc     = pc + ADDR_W'(1);
  assign br_rel_tgt = pc + ADDR_W'(EXT_W'(signed'(br_imm)));
  assign br_abs_tgt = ADDR_W'(br_imm);

  // Bus and status outputs are decoded from the registered state only.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign halted         = (state == HALTED);

  // Next-state and next-register logic. A missing ack in the limit cycle
  // raises the error pulse and restarts the count while the request stays
  // up at the same address; an ack in that same cycle wins.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instruction_d = instruction;
    ir_valid_d    = ir_valid;
    wait_cnt_d    = wait_cnt;
    fetch_err_d   = 1'b0;

    case (state)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (imem.imem_ack) begin
          instruction_d = imem.imem_rdata;
          ir_valid_d    = 1'b1;
          pc_d          = pc_inc;
          wait_cnt_d    = '0;
          state_d       = HOLD;
        end else if (wait_cnt == CNT_LIMIT) begin
          fetch_err_d = 1'b1;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        if (ir_ld) begin
          ir_valid_d = 1'b0;
          if (halt) begin
            state_d = HALTED;
          end else begin
            state_d = FETCH;
            if (br_taken) begin
              pc_d = br_rel ? br_rel_tgt : br_abs_tgt;
            end
          end
        end
      end

      HALTED: begin
        ir_valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any outstanding request at
  // once because imem_req is decoded from the state register.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      ir_valid    <= 1'b0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instruction <= instruction_d;
      ir_valid    <= ir_valid_d;
      wait_cnt    <= wait_cnt_d;
      fetch_err   <= fetch_err_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
// Self-checking bench for ifetch with WAIT_MAX=3. A transaction-level model
// tracks what the fetch stage must present each cycle; directed sequences
// add hand-computed expectations for sequential fetch, branches, PC wrap,
// timeouts, halt and reset during a pending fetch.
// ---------------------------------------------------------------------------
module tb_ifetch;
  localparam int ADDR_W   = 16;
  localparam int WAIT_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_f = 1'b0;
  logic              ir_ld = 1'b0;
  logic              br_taken = 1'b0;
  logic              br_rel = 1'b0;
  logic [15:0]       br_imm = 16'h0;
  logic              halt = 1'b0;
  logic [31:0]       instruction;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;
  logic              halted;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;
  bit  mem_on   = 1'b1;
  bit  force_ack = 1'b0;

  ifetch_if #(.ADDR_W(ADDR_W)) imem ();

  ifetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(16'h0000),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .imem       (imem),
    .ir_ld      (ir_ld),
    .br_taken   (br_taken),
    .br_rel     (br_rel),
    .br_imm     (br_imm),
    .halt       (halt),
    .instruction(instruction),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .fetch_err  (fetch_err),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetch stage is in its transaction (waiting on
  // memory, holding a word, stopped) plus the PC as a plain integer.
  int          m_pc;
  int          m_wait;
  logic [31:0] m_instr;
  bit          m_valid, m_fetching, m_holding, m_halted, m_err;

  always @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      m_pc       <= 0;
      m_wait     <= 0;
      m_instr    <= 32'h0;
      m_valid    <= 1'b0;
      m_fetching <= 1'b0;
      m_holding  <= 1'b0;
      m_halted   <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_halted) begin
        m_valid <= 1'b0;
      end else if (m_fetching) begin
        if (imem.imem_ack) begin
          m_instr    <= imem.imem_rdata;
          m_valid    <= 1'b1;
          m_pc       <= (m_pc + 1) % 65536;
          m_wait     <= 0;
          m_fetching <= 1'b0;
          m_holding  <= 1'b1;
        end else if (m_wait == WAIT_MAX) begin
          m_err  <= 1'b1;
          m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_holding) begin
        if (ir_ld) begin
          m_valid   <= 1'b0;
          m_holding <= 1'b0;
          if (halt) begin
            m_halted <= 1'b1;
          end else begin
            m_fetching <= 1'b1;
            if (br_taken)
              m_pc <= br_rel ? ((m_pc + int'(signed'(br_imm))) & 32'hFFFF) : int'(br_imm);
          end
        end
      end else begin
        m_fetching <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus: controller inputs plus a memory that acks any
  // request in the same cycle with data = address + 0x1000.
  task automatic applyStimulus(input logic ld, input logic hlt, input logic taken,
                               input logic rel, input logic [15:0] imm);
    @(negedge clk);
    #1;
    ir_ld    = ld;
    halt     = hlt;
    br_taken = taken;
    br_rel   = rel;
    br_imm   = imm;
    imem.imem_ack = force_ack | (mem_on & imem.imem_req);
    if (force_ack) imem.imem_rdata = 32'hBAD0_BAD0;
    else if (imem.imem_ack) imem.imem_rdata = {16'h0, imem.imem_addr} + 32'h1000;
    else imem.imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m_imem_req", 32'(imem.imem_req), 32'(m_fetching));
      if (m_fetching) checkOutput("m_imem_addr", 32'(imem.imem_addr), 32'(m_pc));
      checkOutput("m_pc", 32'(pc), 32'(m_pc));
      checkOutput("m_ir_valid", 32'(ir_valid), 32'(m_valid));
      checkOutput("m_instruction", instruction, m_instr);
      checkOutput("m_fetch_err", 32'(fetch_err), 32'(m_err));
      checkOutput("m_halted", 32'(halted), 32'(m_halted));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    #1 rst_f = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("rst_req", 32'(imem.imem_req), 32'h0);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_err", 32'(fetch_err), 32'h0);
    rst_f = 1'b0;
    checkOutput("idle_req", 32'(imem.imem_req), 32'h0);

    // Sequential fetch with a zero-wait memory.
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("seq0_req", 32'(imem.imem_req), 32'h1);
    checkOutput("seq0_addr", 32'(imem.imem_addr), 32'h0);
    checkOutput("seq0_valid", 32'(ir_valid), 32'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);
    checkOutput("seq0_instr", instruction, 32'h1000);
    checkOutput("seq0_valid_c2", 32'(ir_valid), 32'h1);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("seq1_addr", 32'(imem.imem_addr), 32'h1);
    checkOutput("seq1_valid_low", 32'(ir_valid), 32'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);
    checkOutput("seq1_instr", instruction, 32'h1001);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("seq2_addr", 32'(imem.imem_addr), 32'h2);
    applyStimulus(1, 0, 0, 0, 16'h0);
    checkOutput("seq2_instr", instruction, 32'h1002);
    checkOutput("seq2_pc", 32'(pc), 32'h3);
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("seq4_addr", 32'(imem.imem_addr), 32'h4);

    // Relative branch from pc=5 by -3, then absolute branches.
    applyStimulus(1, 0, 1, 1, 16'hFFFD);
    checkOutput("brr_pc_before", 32'(pc), 32'h5);
    checkOutput("brr_instr", instruction, 32'h1004);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("brr_addr", 32'(imem.imem_addr), 32'h2);
    applyStimulus(1, 0, 1, 0, 16'h0040);
    checkOutput("bra_instr_prev", instruction, 32'h1002);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("bra_addr", 32'(imem.imem_addr), 32'h0040);
    applyStimulus(1, 0, 1, 0, 16'hFFFF);
    checkOutput("bra40_instr", instruction, 32'h1040);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("wrap_addr", 32'(imem.imem_addr), 32'hFFFF);
    applyStimulus(1, 0, 0, 0, 16'h0);
    checkOutput("wrap_pc", 32'(pc), 32'h0);
    checkOutput("wrap_instr", instruction, 32'h0001_0FFF);

    // Memory goes silent: timeout pulses every WAIT_MAX+1 cycles.
    mem_on = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("to_addr0", 32'(imem.imem_addr), 32'h0);
    checkOutput("to_req0", 32'(imem.imem_req), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 0, 16'h0);
      checkOutput("to_err", 32'(fetch_err), 32'((k % 4) == 0));
      checkOutput("to_addr", 32'(imem.imem_addr), 32'h0);
      checkOutput("to_valid", 32'(ir_valid), 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    mem_on = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("lim_ack_err", 32'(fetch_err), 32'h0);
    checkOutput("lim_ack_valid", 32'(ir_valid), 32'h1);
    checkOutput("lim_ack_instr", instruction, 32'h1000);
    checkOutput("lim_ack_pc", 32'(pc), 32'h1);

    // Halt wins over a taken branch; inputs afterwards are ignored.
    applyStimulus(1, 1, 1, 0, 16'h1234);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 0, 1, 1, 16'h0005);
      checkOutput("halt_halted", 32'(halted), 32'h1);
      checkOutput("halt_req", 32'(imem.imem_req), 32'h0);
      checkOutput("halt_pc", 32'(pc), 32'h1);
    end
    checkOutput("halt_instr", instruction, 32'h1000);

    // Reset during a fetch whose ack is late; the late ack lands in IDLE.
    applyStimulus(0, 0, 0, 0, 16'h0);
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    mem_on = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("mid_req_before", 32'(imem.imem_req), 32'h1);
    #2 rst_f = 1'b1;
    #1;
    checkOutput("mid_req_abort", 32'(imem.imem_req), 32'h0);
    checkOutput("mid_halted", 32'(halted), 32'h0);
    @(negedge clk);
    #1;
    rst_f = 1'b0;
    force_ack = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hBAD0_BAD0;
    force_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("late_instr", instruction, 32'h0);
    checkOutput("late_valid", 32'(ir_valid), 32'h0);
    checkOutput("late_addr", 32'(imem.imem_addr), 32'h0);
    mem_on = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    checkOutput("restart_instr", instruction, 32'h1000);
    checkOutput("restart_valid", 32'(ir_valid), 32'h1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the SISC processor: holds the program counter, issues reads to instruction memory over a request/acknowledge handshake, and latches the returned word into the instruction register that drives the `instruction` bus of the `sisc` datapath. It advances or redirects the PC when the controller signals that the current instruction is complete, and it supports taken branches, halt, and fetch-timeout detection.

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `WAIT_MAX`, 15, no-ack cycles tolerated in FETCH before `fetch_err` pulses (≥1)
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_f`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  ADDR_W  read address (equals `pc` whenever `imem_req`=1)
- `imem_rdata`  in  32  read data, valid only in a cycle with `imem_ack`=1
- `imem_ack`  in  1  memory acknowledge; completes the outstanding read
- `ir_ld`  in  1  controller: current instruction finished, fetch the next
- `br_taken`  in  1  controller: redirect PC, sampled with `ir_ld`
- `br_rel`  in  1  1 = PC-relative target, 0 = absolute target
- `br_imm`  in  16  branch immediate (`instruction[15:0]`)
- `halt`  in  1  controller: stop fetching, sampled with `ir_ld`
- `instruction`  out  32  instruction register, to `sisc`
- `ir_valid`  out  1  `instruction` holds a fetched, unconsumed word
- `pc`  out  ADDR_W  address of the next word to fetch
- `fetch_err`  out  1  one-cycle pulse on fetch timeout
- `halted`  out  1  block is in HALTED

## Operation
- States: IDLE, FETCH, HOLD, HALTED. Reset → IDLE.
- Reset values: `pc`=RESET_PC, `instruction`=32'h0, `ir_valid`=0, `imem_req`=0, `fetch_err`=0, `halted`=0, wait counter=0.
- IDLE: no request; unconditionally → FETCH next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On edge with `imem_ack`=1: `instruction`←`imem_rdata`, `ir_valid`←1, `pc`←`pc`+1, wait counter←0, → HOLD. Without ack: counter+1.
- Timeout: edge where counter==WAIT_MAX and `imem_ack`=0 → `fetch_err`=1 for next cycle, counter←0, stay FETCH, request stays asserted at same address (retry). Ack in the limit cycle wins; no error.
- HOLD: `imem_req`=0, `instruction` stable. `ir_ld`=0 → stay. `ir_ld`=1 → `ir_valid`←0 and:
  - `halt`=1 → HALTED (halt has priority over `br_taken`; PC unchanged).
  - else `br_taken`=1, `br_rel`=1 → `pc`←`pc`+sign_ext(`br_imm`) (pc already incremented), → FETCH.
  - else `br_taken`=1, `br_rel`=0 → `pc`←`br_imm` zero-extended/truncated to ADDR_W, → FETCH.
  - else → FETCH (pc already sequential).
- HALTED: `halted`=1, `imem_req`=0, `ir_valid`=0, `instruction` keeps last word; leave only by reset.
- PC arithmetic modulo 2^ADDR_W; 0xFFFF+1 wraps to 0 (ADDR_W=16).
- `imem_ack`, `ir_ld`, `br_*`, `halt` ignored in states where not listed.
- Reset asserted mid-fetch aborts the request immediately (asynchronous); a late `imem_ack` after reset release arrives in IDLE and is ignored.

## Timing
- `imem_req`, `ir_valid`, `halted` are Moore/registered; no combinational input→output paths except none (all outputs registered or state-decoded).
- First request: cycle 1 after reset release (IDLE occupies cycle 0).
- Zero-wait memory (ack same cycle as req): `instruction` valid one cycle after ack; reset release → first `ir_valid` at cycle 2.
- `ir_ld` sampled at edge T: `ir_valid` low and new request at T+1; next word valid earliest T+2. Peak throughput one instruction per 2 cycles.
- `fetch_err` high exactly one cycle per timeout; back-to-back timeouts spaced WAIT_MAX+1 cycles.

## Test plan
- Reset release, memory acks every request same cycle with word=addr+32'h1000 → `imem_addr` 0,1,2; `instruction` 32'h1000,32'h1001,32'h1002 with `ir_valid` rising at cycle 2, pc=3 after third fetch when `ir_ld` pulsed each HOLD.
- In HOLD with pc=5, `ir_ld`=1,`br_taken`=1,`br_rel`=1,`br_imm`=16'hFFFD → next `imem_addr`=2; with `br_rel`=0,`br_imm`=16'h0040 → `imem_addr`=16'h0040.
- pc=16'hFFFF fetch acked → pc=0, next sequential fetch at address 0.
- Memory never acks, WAIT_MAX=3 → `fetch_err` pulses every 4 cycles, `imem_addr` constant, `ir_valid` stays 0; ack in counter==3 cycle → no pulse, word latched.
- `ir_ld`=1 with `halt`=1 and `br_taken`=1 → HALTED, `halted`=1, `imem_req` stays 0 for 20 cycles, pc unchanged.
- Assert `rst_f` mid-FETCH with ack delayed, release, then ack arrives → ignored; outputs at reset values, fetch restarts at RESET_PC.
